div_unit: RTL

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It takes the two source operands read from the register file, computes the result over multiple cycles while the core stalls, and returns a single-cycle write-back request (address, data, enable) to the register file write port. Both signed and unsigned forms are handled. Results, including the divide-by-zero and overflow cases, follow the RISC-V M-extension definitions.

---
 rtl/div_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow go IDLE -> FIX directly.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  localparam int unsigned CntW = 6;
  localparam int unsigned RegW = 5;
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [1:0]        op_q, op_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic              ovf_q, ovf_d;
  logic [RegW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;

  logic              is_signed, rs1_neg, rs2_neg, div0, ovf, accept;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   sub, quot, remr, result;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  // Operand decode used on the accepting edge
  always_comb begin
    is_signed = ~i_op[0];
    rs1_neg   = is_signed & i_rs1_data[XLEN-1];
    rs2_neg   = is_signed & i_rs2_data[XLEN-1];
    rs1_mag   = rs1_neg ? neg(i_rs1_data) : i_rs1_data;
    rs2_mag   = rs2_neg ? neg(i_rs2_data) : i_rs2_data;
    div0      = (i_rs2_data == '0);
    ovf       = is_signed & (i_rs1_data == MinNeg) & (&i_rs2_data);
  end

  assign accept = (state_q == S_IDLE) & i_start & ~i_kill;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; kill aborts any non-idle state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
`ifdef DIV_FASTPATH_EN
        if (accept) state_d = (div0 | ovf) ? S_FIX : S_CALC;
`else
        if (accept) state_d = S_CALC;
`endif
      end
      S_CALC:  if (cnt_q == LastIter) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_kill && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Output decode from the next state so the status outputs come straight from flops
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    wren_d = done_d & (rd_addr_q != '0);
  end

  // Datapath: 33-bit trial subtract, sign fix-up and overflow override
  always_comb begin
    shifted   = {rem_q, dvd_q[XLEN-1]};
    ge        = (shifted >= {1'b0, dvs_q});
    sub       = shifted[XLEN-1:0] - dvs_q;
    quot      = ovf_q ? MinNeg : (qsign_q ? neg(dvd_q) : dvd_q);
    remr      = ovf_q ? '0 : (rsign_q ? neg(rem_q) : rem_q);
    result    = op_q[1] ? remr : quot;

    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    op_d      = op_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    ovf_d     = ovf_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;

    if (accept) begin
      op_d      = i_op;
      rd_addr_d = i_rd_addr;
      dvd_d     = rs1_mag;
      dvs_d     = rs2_mag;
      rem_d     = '0;
      cnt_d     = '0;
      // Divide-by-zero quotient is all ones regardless of the dividend sign
      qsign_d   = (rs1_neg ^ rs2_neg) & ~div0;
      rsign_d   = rs1_neg;
      ovf_d     = ovf;
`ifdef DIV_FASTPATH_EN
      if (div0) begin
        dvd_d = '1;
        rem_d = rs1_mag;
      end
`endif
    end else if (state_q == S_CALC) begin
      rem_d = ge ? sub : shifted[XLEN-1:0];
      dvd_d = {dvd_q[XLEN-2:0], ge};
      cnt_d = cnt_q + CntW'(1);
    end else if ((state_q == S_FIX) && (state_d == S_DONE)) begin
      rd_data_d = result;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      op_q      <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wren_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      ovf_q     <= ovf_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wren_q    <= wren_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;
  assign o_rd_wren = wren_q;

endmodule
